// File: rtl/aes_in_packer.sv
// ---------------------------------------------------------------------------
// aes_in_packer
//   Feeds the pipelined AES-128 encryptor. Packs a byte stream into 128-bit
//   blocks (zero-padding a short final block) and drives the cipher's datain
//   and key inputs. A LATENCY-deep {valid, byte count} delay line follows
//   each issued block so that out_valid/out_bytes line up with the cipher's
//   dataout.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   key_in, key_load      key value and load strobe (taken only when idle)
//   key_valid             a key has been loaded since reset
//   in_data/valid/last    byte stream; first byte of a block -> [127:120]
//   in_ready              byte accepted when in_valid && in_ready
//   cipher_datain/key     registered block and key to the cipher
//   blk_valid             one-cycle pulse: datain/key hold a new block
//   out_valid/out_bytes   block on cipher dataout is real / its byte count
//   blk_count             blocks issued since reset (wraps)
// ---------------------------------------------------------------------------

// One register of the valid/byte-count delay line.
module aes_in_packer_dly_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_vld,
    input  logic [4:0] d_bytes,
    output logic       q_vld,
    output logic [4:0] q_bytes
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld   <= 1'b0;
            q_bytes <= 5'd0;
        end else begin
            q_vld   <= d_vld;
            q_bytes <= d_bytes;
        end
    end
endmodule

module aes_in_packer #(
    parameter int LATENCY = 10,
    parameter int NB      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         key_valid,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] cipher_datain,
    output logic [127:0] cipher_key,
    output logic         blk_valid,
    output logic         out_valid,
    output logic [4:0]   out_bytes,
    output logic [31:0]  blk_count
);

    logic [3:0]   byte_cnt;
    logic [127:0] asm_q;
    logic [127:0] merged;
    logic [4:0]   blk_bytes;
    logic         byte_take;
    logic         key_take;
    logic         issue;

    // A key load at a block boundary wins over a waiting byte, so the byte
    // is held off for that cycle rather than racing the key change.
    always_comb begin
        in_ready  = key_valid && !(key_load && byte_cnt == 4'd0);
        byte_take = in_valid && in_ready;
        key_take  = key_load && (byte_cnt == 4'd0) && !byte_take;
        issue     = byte_take && ((byte_cnt == 4'(NB - 1)) || in_last);
    end

    // Drop the incoming byte into its lane. Lanes beyond byte_cnt are still
    // zero in asm_q, which gives the zero padding of short blocks for free.
    for (genvar j = 0; j < NB; j++) begin : g_lane
        assign merged[127-8*j -: 8] = (byte_cnt == 4'(j)) ? in_data
                                                           : asm_q[127-8*j -: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt      <= 4'd0;
            asm_q         <= 128'd0;
            cipher_datain <= 128'd0;
            cipher_key    <= 128'd0;
            key_valid     <= 1'b0;
            blk_valid     <= 1'b0;
            blk_bytes     <= 5'd0;
            blk_count     <= 32'd0;
        end else begin
            blk_valid <= issue;
            if (byte_take) begin
                if (issue) begin
                    asm_q         <= 128'd0;
                    byte_cnt      <= 4'd0;
                    cipher_datain <= merged;
                    blk_bytes     <= {1'b0, byte_cnt} + 5'd1;
                    blk_count     <= blk_count + 32'd1;
                end else begin
                    asm_q    <= merged;
                    byte_cnt <= byte_cnt + 4'd1;
                end
            end
            // The cipher carries the key alongside each block, so changing
            // it here never disturbs blocks already in flight.
            if (key_take) begin
                cipher_key <= key_in;
                key_valid  <= 1'b1;
            end
        end
    end

    // Delay line: tap 0 is the blk_valid cycle, tap LATENCY matches dataout.
    logic [LATENCY:0]      vld_pipe;
    logic [LATENCY:0][4:0] bytes_pipe;

    assign vld_pipe[0]   = blk_valid;
    assign bytes_pipe[0] = blk_bytes;

    for (genvar g = 0; g < LATENCY; g++) begin : g_dly
        aes_in_packer_dly_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .d_vld   (vld_pipe[g]),
            .d_bytes (bytes_pipe[g]),
            .q_vld   (vld_pipe[g+1]),
            .q_bytes (bytes_pipe[g+1])
        );
    end

    assign out_valid = vld_pipe[LATENCY];
    assign out_bytes = bytes_pipe[LATENCY];

endmodule

// File: tb/tb_aes_in_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_in_packer
//   Directed bench for aes_in_packer with LATENCY=10. Inputs change 2 ns
//   after a rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_aes_in_packer;
    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_valid;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] cipher_datain;
    logic [127:0] cipher_key;
    logic         blk_valid;
    logic         out_valid;
    logic [4:0]   out_bytes;
    logic [31:0]  blk_count;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_in_packer #(.LATENCY(LAT), .NB(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_load      (key_load),
        .key_valid     (key_valid),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .cipher_datain (cipher_datain),
        .cipher_key    (cipher_key),
        .blk_valid     (blk_valid),
        .out_valid     (out_valid),
        .out_bytes     (out_bytes),
        .blk_count     (blk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present n bytes of v (MSB first) on consecutive cycles.
    task automatic feed(input logic [127:0] v, input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            in_data  = v[127-8*i -: 8];
            in_valid = 1'b1;
            in_last  = last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the blk_valid cycle: out_valid must rise exactly
    // LAT cycles later with the given byte count.
    task automatic expect_out(input logic [4:0] nbytes);
        tick();
        chk("blk_valid_pulse", blk_valid, 1'b0);
        repeat (LAT - 2) tick();
        chk("out_valid_early", out_valid, 1'b0);
        tick();
        chk("out_valid_on_time", out_valid, 1'b1);
        chk("out_bytes", out_bytes, nbytes);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst_n = 1'b0; key_in = '0; key_load = 1'b0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) tick();
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_datain", cipher_datain, '0);
        chk("rst_key", cipher_key, '0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bytes", out_bytes, '0);
        chk("rst_blk_count", blk_count, '0);
        rst_n = 1'b1;
        tick();

        // No key yet: bytes are refused.
        in_valid = 1'b1; in_data = 8'h55;
        #1 chk("nokey_in_ready", in_ready, 1'b0);
        tick(); tick();
        chk("nokey_blk_count", blk_count, '0);
        chk("nokey_key_valid", key_valid, 1'b0);

        // Key load contends with a waiting byte at byte_cnt 0: key wins.
        key_in = K1; key_load = 1'b1; in_data = 8'h00;
        #1 chk("keyload_stall", in_ready, 1'b0);
        tick();
        key_load = 1'b0;
        chk("key_valid_set", key_valid, 1'b1);
        chk("key_loaded", cipher_key, K1);
        #1 chk("ready_after_key", in_ready, 1'b1);

        // Full block; the stalled 0x00 must be byte 0 of it.
        feed(128'h00112233445566778899aabbccddeeff, 16, 1'b0);
        chk("blk1_valid", blk_valid, 1'b1);
        chk("blk1_data", cipher_datain, 128'h00112233445566778899aabbccddeeff);
        chk("blk1_count", blk_count, 32'd1);
        expect_out(5'd16);

        // Short block with in_last: zero padded.
        feed({24'haabbcc, 104'h0}, 3, 1'b1);
        chk("short_valid", blk_valid, 1'b1);
        chk("short_data", cipher_datain, {24'haabbcc, 104'h0});
        chk("short_count", blk_count, 32'd2);
        expect_out(5'd3);

        // 48 bytes back to back: three issues 16 cycles apart, no bubbles.
        for (int c = 0; c < 70; c++) begin
            in_valid = (c < 48);
            in_data  = 8'(c);
            tick();
            chk("stream_blk_valid", blk_valid, (c < 48) && (c % 16 == 15));
            chk("stream_out_valid", out_valid,
                (c >= 25) && (c <= 57) && ((c - 25) % 16 == 0));
            if (out_valid) chk("stream_out_bytes", out_bytes, 5'd16);
            if (c == 47)
                chk("stream_blk3_data", cipher_datain, 128'h202122232425262728292a2b2c2d2e2f);
        end
        in_valid = 1'b0;
        chk("stream_count", blk_count, 32'd5);

        // key_load mid-block (byte_cnt 5) is ignored.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                in_valid = 1'b0; key_in = K2; key_load = 1'b1;
                tick();
                key_load = 1'b0;
                chk("midblk_key_ignored", cipher_key, K1);
            end
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("blkA_valid", blk_valid, 1'b1);
        chk("blkA_data", cipher_datain, 128'h101112131415161718191a1b1c1d1e1f);
        chk("blkA_key", cipher_key, K1);

        // New key between blocks while block A is in flight.
        key_in = K2; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("gap_blk_valid", blk_valid, 1'b0);
        chk("blkB_key_loaded", cipher_key, K2);
        feed({16'he1e2, 112'h0}, 2, 1'b1);
        chk("blkB_valid", blk_valid, 1'b1);
        chk("blkB_data", cipher_datain, {16'he1e2, 112'h0});
        chk("blkB_key", cipher_key, K2);
        chk("blkB_count", blk_count, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("inflight_out_valid", out_valid, (k == 7) || (k == 10));
            if (k == 7)  chk("inflight_A_bytes", out_bytes, 5'd16);
            if (k == 10) chk("inflight_B_bytes", out_bytes, 5'd2);
        end

        // Two blocks in flight plus 7 bytes pending, then async reset.
        feed({16'h3132, 112'h0}, 2, 1'b1);
        feed({16'h4142, 112'h0}, 2, 1'b1);
        chk("pre_rst_count", blk_count, 32'd9);
        feed({56'h50515253545556, 72'h0}, 7, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_bytes", out_bytes, '0);
        chk("arst_blk_valid", blk_valid, 1'b0);
        chk("arst_blk_count", blk_count, '0);
        chk("arst_key_valid", key_valid, 1'b0);
        chk("arst_datain", cipher_datain, '0);
        chk("arst_key", cipher_key, '0);
        chk("arst_in_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("post_rst_no_out_valid", 32'(seen), 32'd0);

        key_in = K1; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        feed({24'h778899, 104'h0}, 3, 1'b1);
        chk("post_rst_data", cipher_datain, {24'h778899, 104'h0});
        chk("post_rst_count", blk_count, 32'd1);
        expect_out(5'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
